// File: rtl/nios_system_sample_out_pkg.sv
// Shared register map and bit positions for the sample output peripheral.
package nios_system_sample_out_pkg;

  typedef enum logic [1:0] {
    REG_DATA      = 2'd0,
    REG_STATUS    = 2'd1,
    REG_CONTROL   = 2'd2,
    REG_THRESHOLD = 2'd3
  } reg_addr_e;

  localparam int STAT_FULL_BIT      = 16;
  localparam int STAT_EMPTY_BIT     = 17;
  localparam int STAT_UNDERFLOW_BIT = 18;
  localparam int STAT_OVERFLOW_BIT  = 19;

  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_FLUSH_BIT  = 1;
  localparam int CTRL_IRQ_EN_BIT = 2;

  localparam int LEVEL_W = 9;

endpackage

// File: rtl/nios_system_sample_out_fifo.sv
// Synchronous sample FIFO with show-ahead head, flush and occupancy level.
module sample_fifo #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [DATA_W-1:0]     din,
  output logic [DATA_W-1:0]     head,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   LVL_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  push_ok;
  logic                  pop_ok;

  // A full FIFO still accepts a push when a pop frees a slot the same cycle.
  assign full    = level[DEPTH_LOG2];
  assign empty   = (level == '0);
  assign pop_ok  = pop & ~empty & ~flush;
  assign push_ok = push & ~flush & (~full | pop_ok);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/nios_system_sample_out.sv
// Avalon-MM audio sample output: software queues samples, sample_tick plays them out.
module nios_system_sample_out
  import nios_system_sample_out_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic              sample_tick,
  output logic [DATA_W-1:0] out_port,
  output logic              irq
);

  logic                  wr;
  logic                  push;
  logic                  flush;
  logic                  tick_en;
  logic                  pop;
  logic                  underflow_set;
  logic                  overflow_set;
  logic                  enable;
  logic                  irq_en;
  logic                  underflow;
  logic                  overflow;
  logic [LEVEL_W-1:0]    threshold;
  logic [DATA_W-1:0]     head;
  logic [DEPTH_LOG2:0]   level;
  logic [LEVEL_W-1:0]    level9;
  logic                  full;
  logic                  empty;
  logic                  unused_wdata;

  assign wr      = chipselect & ~write_n;
  assign push    = wr & (address == REG_DATA);
  assign flush   = wr & (address == REG_CONTROL) & writedata[CTRL_FLUSH_BIT];
  assign tick_en = sample_tick & enable;
  assign pop     = tick_en & ~empty;
  assign level9  = LEVEL_W'(level);
  assign unused_wdata = ^writedata;

  // Flush swallows any coincident tick, so it must not raise the sticky flags either.
  assign underflow_set = tick_en & empty & ~flush;
  assign overflow_set  = push & full & ~pop & ~flush;

  sample_fifo #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (writedata[DATA_W-1:0]),
    .head  (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      out_port  <= '0;
      enable    <= 1'b0;
      irq_en    <= 1'b0;
      threshold <= '0;
      underflow <= 1'b0;
      overflow  <= 1'b0;
      irq       <= 1'b0;
    end else begin
      if (flush)    out_port <= '0;
      else if (pop) out_port <= head;

      if (wr && address == REG_CONTROL) begin
        enable <= writedata[CTRL_ENABLE_BIT];
        irq_en <= writedata[CTRL_IRQ_EN_BIT];
      end
      if (wr && address == REG_THRESHOLD) threshold <= writedata[LEVEL_W-1:0];

      // A flag event in the same cycle as its clear wins.
      if (underflow_set)
        underflow <= 1'b1;
      else if (wr && address == REG_STATUS && writedata[STAT_UNDERFLOW_BIT])
        underflow <= 1'b0;
      if (overflow_set)
        overflow <= 1'b1;
      else if (wr && address == REG_STATUS && writedata[STAT_OVERFLOW_BIT])
        overflow <= 1'b0;

      irq <= irq_en & ((level9 <= threshold) | underflow);
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      REG_DATA: readdata = 32'(out_port);
      REG_STATUS: begin
        readdata[LEVEL_W-1:0]        = level9;
        readdata[STAT_FULL_BIT]      = full;
        readdata[STAT_EMPTY_BIT]     = empty;
        readdata[STAT_UNDERFLOW_BIT] = underflow;
        readdata[STAT_OVERFLOW_BIT]  = overflow;
      end
      REG_CONTROL: begin
        readdata[CTRL_ENABLE_BIT] = enable;
        readdata[CTRL_IRQ_EN_BIT] = irq_en;
      end
      REG_THRESHOLD: readdata[LEVEL_W-1:0] = threshold;
      default: readdata = '0;
    endcase
  end

endmodule

// File: doc/nios_system_sample_out.md
NIOS_SYSTEM_SAMPLE_OUT -- requirements
Module: nios_system_sample_out

Interface
REQ-001 SHALL have parameter DATA_W, default 16, output sample width (1..32).
REQ-002 SHALL have parameter DEPTH_LOG2, default 4, FIFO depth = 2**DEPTH_LOG2 (2..8).
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port address  input  2  Avalon-MM register select.
REQ-006 SHALL have port chipselect  input  1  slave select.
REQ-007 SHALL have port write_n  input  1  active-low write strobe.
REQ-008 SHALL have port writedata  input  32  write data.
REQ-009 SHALL have port readdata  output  32  combinational read data, zero wait states, unused bits 0.
REQ-010 SHALL have port sample_tick  input  1  one-cycle pulse per audio sample period.
REQ-011 SHALL have port out_port  output  DATA_W  current output sample, registered.
REQ-012 SHALL have port irq  output  1  level-sensitive interrupt, registered.

Function
REQ-013 SHALL decode write as chipselect & ~write_n; no read side effects.
REQ-014 SHALL map address 0 DATA: write pushes writedata[DATA_W-1:0]; read returns out_port zero-extended.
REQ-015 SHALL map address 1 STATUS: [8:0] level, bit16 full, bit17 empty, bit18 underflow (sticky), bit19 overflow (sticky); writing 1 to bit18/19 clears it.
REQ-016 SHALL map address 2 CONTROL: bit0 enable, bit1 flush (write-only, self-clearing, reads 0), bit2 irq_en.
REQ-017 SHALL map address 3 THRESHOLD: [8:0] low-water mark, read/write.
REQ-018 SHALL, on sample_tick with enable=1 and level>0, pop head into out_port; out_port changes on the edge after the tick cycle (1-cycle latency).
REQ-019 SHALL, on sample_tick with enable=1 and level=0, hold out_port and set underflow.
REQ-020 SHALL ignore sample_tick when enable=0 (no pop, no underflow).
REQ-021 SHALL drop a push when full and no pop occurs that cycle, and set overflow.
REQ-022 SHALL accept push and pop in the same cycle when full (level unchanged); when empty, the pop underflows and the push is stored (no bypass).
REQ-023 SHALL, on flush, zero level and pointers and out_port in one cycle; flush has priority over a simultaneous push/pop (both discarded).
REQ-024 SHALL give a same-cycle sticky-flag set priority over its write-1-to-clear.
REQ-025 SHALL drive irq = irq_en & (level <= THRESHOLD | underflow), registered one cycle after the condition.
REQ-026 SHALL compute level in DEPTH_LOG2+1 bits; pointers wrap modulo depth.

Reset
REQ-027 SHALL, while reset is high at a clk edge, clear out_port, level, pointers, underflow, overflow, CONTROL, THRESHOLD, irq to 0.
REQ-028 SHALL, on reset mid-operation, discard FIFO contents; memory array needs no reset.

Structure
REQ-029 SHALL place register address constants and STATUS/CONTROL bit positions in a shared package nios_system_sample_out_pkg.
REQ-030 SHALL instantiate one sub-module sample_fifo (sync FIFO: push, pop, flush, level, full, empty).

Verification
REQ-031 Reset, then read addr 1 -> 0x00020000 (empty), out_port=0, irq=0.
REQ-032 Write CONTROL=1, push 0x1234, 0xABCD, tick -> out_port=0x1234 next cycle; tick -> 0xABCD; tick -> hold 0xABCD, STATUS bit18=1.
REQ-033 DEPTH_LOG2=4: 17 pushes, no tick -> level=16, full=1, overflow=1; 17th value never output.
REQ-034 Full FIFO, push and tick same cycle -> level stays 16, pushed value output 16 ticks later.
REQ-035 THRESHOLD=2, irq_en=1, 4 samples queued, 2 ticks -> irq=1 one cycle after level reaches 2; write 0x40000 to STATUS clears only underflow.
REQ-036 Flush coincident with push and tick -> level=0, out_port=0, no underflow/overflow set.
